// File: rtl/uart_bus_bridge_if.sv
// uart_bus_bridge_if: single-byte system bus driven by the serial host bridge
interface uart_bus_bridge_if;
  logic        bus_cs;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic [7:0]  bus_din;
  modport master (output bus_cs, bus_we, bus_addr, bus_dout, input bus_din);
  modport slave  (input bus_cs, bus_we, bus_addr, bus_dout, output bus_din);
endinterface

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: 8N1 host-command engine doing single-byte bus reads/writes
module uart_bus_bridge #(
  parameter int CLK_FREQ = 29000000,
  parameter int BAUD     = 115200
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic tx,
  output logic busy,
  uart_bus_bridge_if.master bus
);
  localparam int SYM  = CLK_FREQ / BAUD;
  localparam int CW   = $clog2(SYM);
  localparam int HALF = SYM / 2;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, ADDR_H, ADDR_L, DATA, BUS, CAPTURE, RESP} state_t;
  logic [2:0]    rx_sh;
  rx_state_t     r_state;
  logic [CW-1:0] rcnt;
  logic [2:0]    rbit;
  logic [7:0]    rx_byte;
  logic          rx_stb, rx_err;
  logic          t_busy;
  logic [CW-1:0] tcnt;
  logic [3:0]    tbit;
  logic [8:0]    tsh;
  state_t        state;
  logic          op_w, sent;
  logic [7:0]    resp;
  logic          tx_start;
  assign tx_start = state == RESP && !sent;
  // rx_sh[1] is the synchronized line, rx_sh[2] its previous value for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sh   <= 3'b111;
      r_state <= R_IDLE;
      rcnt    <= '0;
      rbit    <= '0;
      rx_byte <= '0;
      rx_stb  <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      rx_sh  <= {rx_sh[1:0], rx};
      rx_stb <= 1'b0;
      rx_err <= 1'b0;
      case (r_state)
        R_IDLE: if (rx_sh[2] && !rx_sh[1]) begin
          r_state <= R_START;
          rcnt    <= '0;
        end
        R_START: if (rcnt == CW'(HALF - 1)) begin
          rcnt    <= '0;
          rbit    <= '0;
          r_state <= rx_sh[1] ? R_IDLE : R_DATA;
        end else rcnt <= rcnt + 1'b1;
        R_DATA: if (rcnt == CW'(SYM - 1)) begin
          rcnt    <= '0;
          rx_byte <= {rx_sh[1], rx_byte[7:1]};
          rbit    <= rbit + 1'b1;
          r_state <= rbit == 3'd7 ? R_STOP : R_DATA;
        end else rcnt <= rcnt + 1'b1;
        default: if (rcnt == CW'(SYM - 1)) begin
          rcnt    <= '0;
          rx_stb  <= rx_sh[1];
          rx_err  <= !rx_sh[1];
          r_state <= R_IDLE;
        end else rcnt <= rcnt + 1'b1;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx     <= 1'b1;
      t_busy <= 1'b0;
      tcnt   <= '0;
      tbit   <= '0;
      tsh    <= '0;
    end else if (tx_start) begin
      tx     <= 1'b0;
      tsh    <= {1'b1, resp};
      tcnt   <= '0;
      tbit   <= '0;
      t_busy <= 1'b1;
    end else if (t_busy) begin
      if (tcnt == CW'(SYM - 1)) begin
        tcnt   <= '0;
        tbit   <= tbit + 1'b1;
        tx     <= tbit == 4'd9 ? 1'b1 : tsh[0];
        tsh    <= {1'b0, tsh[8:1]};
        t_busy <= tbit != 4'd9;
      end else tcnt <= tcnt + 1'b1;
    end
  end
  // Bytes arriving in BUS, CAPTURE or RESP fall through the case and are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      op_w         <= 1'b0;
      sent         <= 1'b0;
      resp         <= '0;
      bus.bus_cs   <= 1'b0;
      bus.bus_we   <= 1'b0;
      bus.bus_addr <= '0;
      bus.bus_dout <= '0;
    end else begin
      bus.bus_cs <= 1'b0;
      bus.bus_we <= 1'b0;
      if (rx_err) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else case (state)
        IDLE: if (rx_stb) begin
          busy  <= 1'b1;
          op_w  <= rx_byte == 8'h57;
          resp  <= 8'h3F;
          sent  <= 1'b0;
          state <= rx_byte == 8'h57 || rx_byte == 8'h52 ? ADDR_H : RESP;
        end
        ADDR_H: if (rx_stb) begin
          bus.bus_addr[15:8] <= rx_byte;
          state              <= ADDR_L;
        end
        ADDR_L: if (rx_stb) begin
          bus.bus_addr[7:0] <= rx_byte;
          bus.bus_cs        <= !op_w;
          state             <= op_w ? DATA : BUS;
        end
        DATA: if (rx_stb) begin
          bus.bus_dout <= rx_byte;
          bus.bus_cs   <= 1'b1;
          bus.bus_we   <= 1'b1;
          state        <= BUS;
        end
        BUS: begin
          resp  <= 8'h4B;
          sent  <= 1'b0;
          state <= op_w ? RESP : CAPTURE;
        end
        CAPTURE: begin
          resp  <= bus.bus_din;
          sent  <= 1'b0;
          state <= RESP;
        end
        default: if (!sent) sent <= 1'b1;
        else if (!t_busy) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: directed command/response checks against a simple bus slave model
module tb_uart_bus_bridge;
  localparam int SYM = 29;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic tx, busy;
  int n_cmp = 0, n_bad = 0;
  int cs_total = 0;
  logic        cap_we;
  logic [15:0] cap_addr;
  logic [7:0]  cap_dout;
  logic [15:0] waddr = '0;
  logic [7:0]  wdata = '0;
  logic        wvalid = 1'b0;
  logic [8:0]  txq[$];
  uart_bus_bridge_if bus_if ();
  uart_bus_bridge #(.CLK_FREQ(29000000), .BAUD(1000000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .tx(tx), .busy(busy), .bus(bus_if)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus_if.bus_cs) begin
      cs_total <= cs_total + 1;
      cap_we   <= bus_if.bus_we;
      cap_addr <= bus_if.bus_addr;
      cap_dout <= bus_if.bus_dout;
      if (bus_if.bus_we) begin
        waddr  <= bus_if.bus_addr;
        wdata  <= bus_if.bus_dout;
        wvalid <= 1'b1;
      end else
        bus_if.bus_din <= bus_if.bus_addr == 16'hFFFC ? 8'h5C :
                          wvalid && bus_if.bus_addr == waddr ? wdata :
                          bus_if.bus_addr[15:8] ^ bus_if.bus_addr[7:0] ^ 8'h96;
    end
  end
  // tx decoder: pushes {stop, data} for every frame seen on tx
  initial forever begin
    logic [7:0] b;
    @(negedge clk);
    if (tx === 1'b0 && !rst) begin
      repeat (SYM / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (SYM) @(negedge clk);
        b[i] = tx;
      end
      repeat (SYM) @(negedge clk);
      txq.push_back({tx, b});
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b, input int pct = 0, input logic stop = 1'b1);
    logic [9:0] f;
    int t;
    f = {stop, b, 1'b0};
    t = 0;
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      while (t < ((i + 1) * SYM * (100 + pct) + 50) / 100) begin
        @(negedge clk);
        t++;
      end
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  task automatic expect_resp(input string tag, input logic [8:0] exp);
    int n;
    logic [8:0] got;
    n = 0;
    while (txq.size() == 0 && n < 25 * SYM) begin
      @(negedge clk);
      n++;
    end
    got = txq.size() != 0 ? txq.pop_front() : 9'h0EE;
    chk(tag, {23'd0, got}, {23'd0, exp});
  endtask
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 25 * SYM) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask
  initial begin
    int base;
    repeat (5) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_cs", {31'd0, bus_if.bus_cs}, 32'd0);
    chk("rst_we", {31'd0, bus_if.bus_we}, 32'd0);
    chk("rst_addr", {16'd0, bus_if.bus_addr}, 32'd0);
    chk("rst_dout", {24'd0, bus_if.bus_dout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    base = cs_total;
    send(8'h57);
    chk("w_busy_rise", {31'd0, busy}, 32'd1);
    send(8'h12); send(8'h34); send(8'hA5);
    expect_resp("w_resp", 9'h14B);
    chk("w_cs_count", cs_total - base, 32'd1);
    chk("w_we", {31'd0, cap_we}, 32'd1);
    chk("w_addr", {16'd0, cap_addr}, 32'h1234);
    chk("w_dout", {24'd0, cap_dout}, 32'hA5);
    wait_idle("w_busy_fall");
    chk("addr_hold", {16'd0, bus_if.bus_addr}, 32'h1234);
    base = cs_total;
    send(8'h52); send(8'hFF); send(8'hFC);
    expect_resp("r_resp", 9'h15C);
    chk("r_cs_count", cs_total - base, 32'd1);
    chk("r_we", {31'd0, cap_we}, 32'd0);
    chk("r_addr", {16'd0, cap_addr}, 32'hFFFC);
    wait_idle("r_busy_fall");
    send(8'h52); send(8'h12); send(8'h34);
    expect_resp("r_back", 9'h1A5);
    wait_idle("rb_busy_fall");
    base = cs_total;
    send(8'h41);
    expect_resp("bad_resp", 9'h13F);
    chk("bad_cs", cs_total - base, 32'd0);
    wait_idle("bad_busy_fall");
    base = cs_total;
    send(8'h57); send(8'h12); send(8'h34, 0, 1'b0);
    repeat (5) @(negedge clk);
    chk("fe_idle", {31'd0, busy}, 32'd0);
    repeat (12 * SYM) @(negedge clk);
    chk("fe_no_tx", txq.size(), 32'd0);
    chk("fe_cs", cs_total - base, 32'd0);
    send(8'h52); send(8'h00); send(8'h00);
    expect_resp("fe_recover", 9'h196);
    wait_idle("fe_busy_fall");
    base = cs_total;
    rx = 1'b0;
    repeat (9) @(negedge clk);
    rx = 1'b1;
    repeat (12 * SYM) @(negedge clk);
    chk("glitch_busy", {31'd0, busy}, 32'd0);
    chk("glitch_no_tx", txq.size(), 32'd0);
    chk("glitch_cs", cs_total - base, 32'd0);
    send(8'h52, 2); send(8'hFF, 2); send(8'hFC, 2);
    expect_resp("slow_resp", 9'h15C);
    wait_idle("slow_busy_fall");
    send(8'h57, -2); send(8'h00, -2); send(8'h77, -2); send(8'h3C, -2);
    expect_resp("fast_resp", 9'h14B);
    chk("fast_addr", {16'd0, cap_addr}, 32'h0077);
    chk("fast_dout", {24'd0, cap_dout}, 32'h3C);
    wait_idle("fast_busy_fall");
    send(8'h52); send(8'h00); send(8'h77);
    expect_resp("fast_back", 9'h13C);
    wait_idle("fb_busy_fall");
    send(8'h52); send(8'hFF); send(8'hFC);
    begin
      int n;
      n = 0;
      while (tx !== 1'b0 && n < 10 * SYM) begin
        @(negedge clk);
        n++;
      end
      chk("rr_tx_start", {31'd0, tx}, 32'd0);
    end
    repeat (3 * SYM) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rr_tx", {31'd0, tx}, 32'd1);
    chk("rr_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (12 * SYM) @(negedge clk);
    txq.delete();
    send(8'h52); send(8'hFF); send(8'hFC);
    expect_resp("rr_recover", 9'h15C);
    wait_idle("rr_busy_fall");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
